// File: rtl/sdram_test_pkg.sv
// Shared definitions for the SDRAM read/write self-test: FSM states and the
// pass-dependent data pattern.
package sdram_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Address plus the pass nibble replicated four times; callers truncate to their data width.
  function automatic logic [31:0] pattern(input logic [31:0] a, input logic [3:0] p);
    return a + {16'h0000, p, p, p, p};
  endfunction

endpackage

// File: rtl/sdram_resp_checker.sv
// Read-response side of the self-test: counts returned words, rebuilds the
// expected pattern for each and keeps the sticky error flag.
module sdram_resp_checker
  import sdram_test_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 10,
  parameter int ADDR_DEPTH = 1024
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              cmp_en,
  input  logic              stray,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  input  logic [3:0]        pass,
  output logic              last_resp,
  output logic              error_flag
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ADDR_DEPTH - 1);

  logic [ADDR_W-1:0] rc_q, rc_d;
  logic              error_q, error_d;
  logic [DATA_W-1:0] exp_data;
  logic              hit;

  always_comb begin
    exp_data  = DATA_W'(pattern(32'(rc_q), pass));
    hit       = cmp_en && rd_valid;
    last_resp = hit && (rc_q == LAST_ADDR);
    rc_d      = rc_q;
    if (clear || last_resp) begin
      rc_d = '0;
    end else if (hit) begin
      rc_d = rc_q + ADDR_W'(1);
    end
    // Sticky: only rst_n clears it, a dropped init_done does not.
    error_d = error_q | stray | (hit && (rd_data != exp_data));
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      rc_q    <= '0;
      error_q <= 1'b0;
    end else begin
      rc_q    <= rc_d;
      error_q <= error_d;
    end
  end

  assign error_flag = error_q;

endmodule

// File: rtl/sdram_rw_checker.sv
// SDRAM self-test traffic engine: writes a pass-dependent pattern over the
// address range, reads it back, and loops while the controller is ready.
module sdram_rw_checker
  import sdram_test_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 10,
  parameter int ADDR_DEPTH = 1024
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic              init_done,
  output logic              wr_en,
  input  logic              wr_rdy,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_en,
  input  logic              rd_rdy,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              error_flag,
  output logic [3:0]        cycle_countor,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  // Handshake: a word moves on a cycle where *_en and *_rdy are both high; an
  // unaccepted request keeps its address/data unchanged; rd_valid returns in request order.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ADDR_DEPTH - 1);

  state_t            state_q, state_d;
  logic              wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] wa_q, wa_d, ra_q, ra_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic [3:0]        p_q, p_d;
  logic              wr_fire, rd_fire, last_resp, cmp_en, stray;

  function automatic logic [DATA_W-1:0] word_at(input logic [ADDR_W-1:0] a, input logic [3:0] p);
    return DATA_W'(pattern(32'(a), p));
  endfunction

  assign wr_fire = wr_en_q && wr_rdy;
  assign rd_fire = rd_en_q && rd_rdy;
  assign cmp_en  = init_done && (state_q == ST_READ || state_q == ST_DRAIN);
  assign stray   = init_done && rd_valid && (state_q == ST_IDLE || state_q == ST_WRITE);

  always_comb begin
    state_d = state_q;
    wr_en_d = wr_en_q;
    rd_en_d = rd_en_q;
    wa_d    = wa_q;
    ra_d    = ra_q;
    wd_d    = wd_q;
    p_d     = p_q;
    if (!init_done) begin
      // Controller lost: abandon the pass but keep the pass count.
      state_d = ST_IDLE;
      wr_en_d = 1'b0;
      rd_en_d = 1'b0;
      wa_d    = '0;
      ra_d    = '0;
      wd_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_WRITE;
          wr_en_d = 1'b1;
          wa_d    = '0;
          wd_d    = word_at('0, p_q);
        end
        ST_WRITE: begin
          if (wr_fire) begin
            if (wa_q == LAST_ADDR) begin
              state_d = ST_READ;
              wr_en_d = 1'b0;
              wa_d    = '0;
              wd_d    = '0;
              rd_en_d = 1'b1;
              ra_d    = '0;
            end else begin
              wa_d = wa_q + ADDR_W'(1);
              wd_d = word_at(wa_q + ADDR_W'(1), p_q);
            end
          end
        end
        ST_READ: begin
          if (rd_fire) begin
            if (ra_q == LAST_ADDR) begin
              state_d = ST_DRAIN;
              rd_en_d = 1'b0;
              ra_d    = '0;
            end else begin
              ra_d = ra_q + ADDR_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (last_resp) begin
            state_d = ST_WRITE;
            p_d     = p_q + 4'd1;
            wr_en_d = 1'b1;
            wa_d    = '0;
            wd_d    = word_at('0, p_q + 4'd1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      wa_q    <= '0;
      ra_q    <= '0;
      wd_q    <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      wr_en_q <= wr_en_d;
      rd_en_q <= rd_en_d;
      wa_q    <= wa_d;
      ra_q    <= ra_d;
      wd_q    <= wd_d;
      p_q     <= p_d;
    end
  end

  sdram_resp_checker #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .ADDR_DEPTH(ADDR_DEPTH)
  ) u_resp (
    .clk_50m   (clk_50m),
    .rst_n     (rst_n),
    .clear     (!init_done),
    .cmp_en    (cmp_en),
    .stray     (stray),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .pass      (p_q),
    .last_resp (last_resp),
    .error_flag(error_flag)
  );

  assign wr_en         = wr_en_q;
  assign wr_addr       = wa_q;
  assign wr_data       = wd_q;
  assign rd_en         = rd_en_q;
  assign rd_addr       = ra_q;
  assign cycle_countor = p_q;
  assign busy          = (state_q != ST_IDLE);
  assign state_dbg     = state_q;

endmodule
